ofifo_bank: RTL
===============

Name: ofifo_bank

Overview:
- Output FIFO bank between the MAC array columns and the SFP stage.
- Each MAC column pushes its partial-sum word independently into its own FIFO.
- The bank presents one row (all columns) to the SFP only when every column holds data.
- It produces the ofifo_full and ofifo_valid status consumed by the controller, and is popped by the controller's ofifo read instruction bit.

Parameters:
- COL, 8, number of MAC columns / per-column FIFOs
- BW, 16, width of one column word in bits
- DEPTH, 16, entries per column FIFO; must be a power of two, at least 2
- PTR_W, $clog2(DEPTH), pointer index width (derived; not overridden)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- wr  in  COL  per-column push strobe
- in  in  COL*BW  column data; column c occupies bits [c*BW +: BW]
- rd  in  1  pop one word from every column simultaneously
- out  out  COL*BW  head row, same packing as in; all zeros when o_valid=0
- o_valid  out  1  every column non-empty
- o_full  out  1  any column full
- o_ready  out  1  equals ~o_full
- o_count  out  PTR_W+1  occupancy of the least-filled column (0..DEPTH)
- o_err  out  2  sticky: [0] overflow (push to full column), [1] underflow (rd while !o_valid)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset is sampled on the clk rising edge and clears everything except storage:
  - all read/write pointers = 0, all counts = 0
  - o_valid=0, o_full=0, o_ready=1, o_count=0, o_err=2'b00, out=0
  - storage contents are not reset
- Reset asserted mid-operation discards all queued data in that same edge; wr/rd in that cycle are ignored.
- Per-column pointers are PTR_W+1 bits, with the MSB as the wrap bit:
  - empty when the pointers are equal
  - full when the index bits are equal and the wrap bits differ
  - pointers wrap naturally from DEPTH-1 to 0
- Push: when wr[c]=1 and column c is not full, in[c] is written at wptr[c] and wptr[c] increments at that edge.
- Push to a full column: ignored unless a pop happens in the same cycle. Otherwise the data is dropped, o_err[0] is set, and pointers are unchanged.
- Pop: when rd=1 and o_valid=1, every column's rptr increments at the edge.
- Pop while not valid: rd=1 with o_valid=0 moves no pointers and sets o_err[1].
- Simultaneous push and pop on one column:
  - both take effect; count is unchanged
  - this is allowed even when the column is full, because the pop frees the slot first
  - on an empty column this cannot occur, because o_valid=0 blocks the pop
- out is first-word fall-through: combinational read of mem[rptr] per column, masked to 0 when o_valid=0.
- Status is derived from registered pointers, so it updates in the cycle after the causing edge:
  - o_valid = AND over columns of non-empty
  - o_full = OR over columns of full
- Write-to-valid latency: the last column's push at edge N gives o_valid=1 and valid out during cycle N+1.
- Back-to-back rd on consecutive cycles is supported; o_valid re-evaluates each cycle.
- o_count = minimum count over all columns, computed combinationally from the registered counts.
- o_err bits are cleared only by reset.

Decomposition:
- Shared package ofifo_pkg:
  - default COL, BW, DEPTH constants
  - err bit index constants ERR_OVF=0, ERR_UDF=1
- One natural sub-module: fifo_col, a single-column FIFO with:
  - inputs clk, reset, wr, rd, in
  - outputs out, empty, full, count
- ofifo_bank instantiates COL copies of fifo_col in a generate loop, gates rd with o_valid, and reduces the status flags (AND for valid, OR for full, minimum for o_count).

Test Plan:
- Reset then idle 3 cycles -> o_valid=0, o_full=0, o_ready=1, o_count=0, o_err=0, out=0.
- Skewed columns:
  - push column c with value 16'h0100+c, columns 0..6 only -> o_valid stays 0
  - then push column 7 -> o_valid=1 in the next cycle
  - out column c = 16'h0100+c
  - rd one cycle -> o_valid=0, o_count=0
- Fill all columns with DEPTH words, value = entry index -> o_full=1 after the DEPTH-th push.
  - 17th push to column 3 -> o_err[0]=1, data dropped
  - 16 pops return 0..15 in order on every column
- Full plus simultaneous wr/rd on all columns -> o_full stays 1, o_count stays 16, output sequence continues without loss.
- rd with o_valid=0 -> o_err[1]=1 and pointers unchanged: a subsequent full row reads back correctly.
- Wrap and reset:
  - wrap test: 40 push/pop rows with data = row number -> all 40 rows returned in order
  - reset mid-stream with 5 rows queued -> next cycle o_valid=0, o_count=0, o_err=0

Source files
------------

// File: rtl/ofifo_pkg.sv
// ofifo_pkg: shared defaults and error-bit positions for the output FIFO bank
package ofifo_pkg;
  localparam int COL_DEF   = 8;
  localparam int BW_DEF    = 16;
  localparam int DEPTH_DEF = 16;
  localparam int ERR_OVF   = 0;
  localparam int ERR_UDF   = 1;
endpackage

// File: rtl/fifo_col.sv
// fifo_col: single-column first-word-fall-through FIFO with wrap-bit pointers
module fifo_col #(
  parameter int BW = 16,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  input  logic [BW-1:0] in,
  output logic [BW-1:0] out,
  output logic          empty,
  output logic          full,
  output logic [PTR_W:0] count
);
  logic [BW-1:0] r_mem [DEPTH];
  logic [PTR_W:0] r_wptr, r_rptr;
  logic w_push;
  assign empty = r_wptr == r_rptr;
  assign full = (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]) && (r_wptr[PTR_W] != r_rptr[PTR_W]);
  assign count = r_wptr - r_rptr;
  // a same-cycle pop frees the slot, so a full column may still accept the push
  assign w_push = wr && (!full || rd);
  assign out = r_mem[r_rptr[PTR_W-1:0]];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (rd) r_rptr <= r_rptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wptr[PTR_W-1:0]] <= in;
  end
endmodule

// File: rtl/ofifo_bank.sv
// ofifo_bank: per-column output FIFOs presenting a full row only when all columns hold data
module ofifo_bank import ofifo_pkg::*; #(
  parameter int COL = COL_DEF,
  parameter int BW = BW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COL-1:0]    wr,
  input  logic [COL*BW-1:0] in,
  input  logic              rd,
  output logic [COL*BW-1:0] out,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic [PTR_W:0]    o_count,
  output logic [1:0]        o_err
);
  logic [COL-1:0] w_empty, w_full, w_ovf;
  logic [COL*BW-1:0] w_data;
  logic [PTR_W:0] w_count [COL];
  logic [PTR_W:0] w_min;
  logic w_rd;
  logic [1:0] r_err;
  assign w_rd = rd && o_valid;
  for (genvar c = 0; c < COL; c++) begin : g_col
    fifo_col #(.BW(BW), .DEPTH(DEPTH)) u_col (
      .clk(clk),
      .reset(reset),
      .wr(wr[c]),
      .rd(w_rd),
      .in(in[c*BW +: BW]),
      .out(w_data[c*BW +: BW]),
      .empty(w_empty[c]),
      .full(w_full[c]),
      .count(w_count[c])
    );
  end
  assign o_valid = ~|w_empty;
  assign o_full = |w_full;
  assign o_ready = ~o_full;
  assign out = o_valid ? w_data : '0;
  assign w_ovf = wr & w_full & {COL{~w_rd}};
  always_comb begin
    w_min = w_count[0];
    for (int c = 1; c < COL; c++) w_min = (w_count[c] < w_min) ? w_count[c] : w_min;
  end
  assign o_count = w_min;
  always_ff @(posedge clk) begin
    if (reset) r_err <= '0;
    else begin
      if (|w_ovf) r_err[ERR_OVF] <= 1'b1;
      if (rd && !o_valid) r_err[ERR_UDF] <= 1'b1;
    end
  end
  assign o_err = r_err;
endmodule
